fc_stream_layer: RTL

Parametrised fully-connected layer with streaming input and N_OUT parallel multiply-accumulate lanes. It sits after the final pooling/flatten stage of the CNN and replaces the fixed 16-input, 2-class parallel layer. Weights and biases are loaded serially over a ready/valid port, and features stream in one per cycle. Each frame produces N_OUT saturated fixed-point class scores plus the argmax class index, behind an output handshake.

---
 rtl/fc_stream_pkg.sv | 32 +++
 rtl/fc_mac_lane.sv | 74 +++++++
 rtl/fc_stream_layer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fc_stream_pkg.sv
// fc_stream_pkg
// Shared types and helpers for the streaming fully-connected layer:
//   state_t   - controller states (LOAD / RUN / OUT)
//   idx_w()   - index width for an N-entry space, never less than 1 bit
//   saturate()- clamp a sign-extended, already-shifted accumulator value to
//               a data_w-bit signed range (caller truncates to data_w bits)
package fc_stream_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  function automatic int idx_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  // Operates on a 128-bit sign-extended value so one function serves any
  // ACC_W / DATA_W combination up to those limits.
  function automatic logic signed [63:0] saturate(input logic signed [127:0] v,
                                                  input int data_w);
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    hi = (128'sd1 <<< (data_w - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (data_w - 1));
    if (v > hi)      return hi[63:0];
    else if (v < lo) return lo[63:0];
    else             return v[63:0];
  endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// fc_mac_lane
// One output class: weight register file, bias, accumulator and the
// shift/saturate/ReLU score stage.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   i_w_we/i_w_addr/i_w_data  weight register file write
//   i_b_we/i_b_data     bias write (also presets the accumulator)
//   i_acc_init          reload accumulator from the stored bias
//   i_acc_en/i_x/i_idx  accumulate i_x * W[i_idx]
//   i_capture/i_relu_en register the score of the post-accumulate value
//   o_score_nxt         score as it would be captured this cycle
//   o_score             registered score
module fc_mac_lane
  import fc_stream_pkg::*;
#(
  parameter int N_IN   = 16,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 40
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_w_we,
  input  logic [idx_w(N_IN)-1:0]      i_w_addr,
  input  logic signed [DATA_W-1:0]    i_w_data,
  input  logic                        i_b_we,
  input  logic signed [DATA_W-1:0]    i_b_data,
  input  logic                        i_acc_init,
  input  logic                        i_acc_en,
  input  logic signed [DATA_W-1:0]    i_x,
  input  logic [idx_w(N_IN)-1:0]      i_idx,
  input  logic                        i_capture,
  input  logic                        i_relu_en,
  output logic signed [DATA_W-1:0]    o_score_nxt,
  output logic signed [DATA_W-1:0]    o_score
);

  logic signed [DATA_W-1:0]   r_w [N_IN];
  logic signed [DATA_W-1:0]   r_bias;
  logic signed [ACC_W-1:0]    r_acc;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_acc_nxt;
  logic signed [ACC_W-1:0]    w_shift;
  logic signed [DATA_W-1:0]   w_sat;

  assign w_prod    = i_x * r_w[i_idx];
  assign w_acc_nxt = r_acc + ACC_W'(w_prod);
  // Score is taken from the value that includes the feature being accepted,
  // so it is ready in the first OUT cycle.
  assign w_shift   = w_acc_nxt >>> FRAC_W;
  assign w_sat     = DATA_W'(saturate(128'(w_shift), DATA_W));
  assign o_score_nxt = (i_relu_en && (w_sat < 0)) ? '0 : w_sat;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_IN; k++) r_w[k] <= '0;
      r_bias  <= '0;
      r_acc   <= '0;
      o_score <= '0;
    end else begin
      if (i_w_we) r_w[i_w_addr] <= i_w_data;
      if (i_b_we) begin
        r_bias <= i_b_data;
        r_acc  <= ACC_W'(i_b_data) <<< FRAC_W;
      end else if (i_acc_init) begin
        r_acc  <= ACC_W'(r_bias) <<< FRAC_W;
      end else if (i_acc_en) begin
        r_acc  <= w_acc_nxt;
      end
      if (i_capture) o_score <= o_score_nxt;
    end
  end

endmodule

// File: rtl/fc_stream_layer.sv
// fc_stream_layer
// Streaming fully-connected layer: serial weight/bias load, one feature per
// cycle into N_OUT MAC lanes, saturated scores plus argmax behind a
// ready/valid output.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   w_valid/w_ready/w_data/w_reload  weight rows then bias row; reload request
//   weights_loaded                   full weight set held
//   relu_en                          clamp negative scores (sampled at capture)
//   in_valid/in_ready/in_data        feature stream
//   out_valid/out_ready              score handshake
//   class_out/class_idx              scores and lowest-index argmax
//
// state   | meaning
// LOAD    | accepting weight rows 0..N_IN-1, then the bias row
// RUN     | accepting features into the accumulators
// OUT     | scores valid, waiting for out_ready
module fc_stream_layer
  import fc_stream_pkg::*;
#(
  parameter int N_IN   = 16,
  parameter int N_OUT  = 2,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 40
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         w_valid,
  output logic                         w_ready,
  input  logic [N_OUT*DATA_W-1:0]      w_data,
  input  logic                         w_reload,
  output logic                         weights_loaded,
  input  logic                         relu_en,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_OUT*DATA_W-1:0]      class_out,
  output logic [idx_w(N_OUT)-1:0]      class_idx
);

  localparam int IW  = idx_w(N_IN);
  localparam int WCW = idx_w(N_IN + 1);
  localparam int CIW = idx_w(N_OUT);

  state_t           r_state;
  logic [WCW-1:0]   r_wcnt;
  logic [IW-1:0]    r_idx;
  logic             r_in_ready;

  logic             w_reload_hit;
  logic             w_w_beat;
  logic             w_row_we;
  logic             w_bias_we;
  logic             w_acc_en;
  logic             w_last;
  logic             w_acc_init;
  logic signed [DATA_W-1:0] w_score_nxt [N_OUT];
  logic signed [DATA_W-1:0] w_best_val;
  logic [CIW-1:0]   w_best_idx;

  // A reload at idx 0 takes the cycle, so no feature is handshaken with it.
  assign w_reload_hit = (r_state == ST_RUN) && w_reload && (r_idx == '0);
  assign in_ready     = r_in_ready && !w_reload_hit;

  assign w_w_beat   = (r_state == ST_LOAD) && w_valid;
  assign w_bias_we  = w_w_beat && (r_wcnt == WCW'(N_IN));
  assign w_row_we   = w_w_beat && !w_bias_we;
  assign w_acc_en   = (r_state == ST_RUN) && in_valid && in_ready;
  assign w_last     = w_acc_en && (r_idx == IW'(N_IN - 1));
  assign w_acc_init = (r_state == ST_OUT) && out_ready;

  for (genvar j = 0; j < N_OUT; j++) begin : g_lane
    fc_mac_lane #(
      .N_IN   (N_IN),
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk         (clk),
      .reset       (reset),
      .i_w_we      (w_row_we),
      .i_w_addr    (r_wcnt[IW-1:0]),
      .i_w_data    (w_data[j*DATA_W +: DATA_W]),
      .i_b_we      (w_bias_we),
      .i_b_data    (w_data[j*DATA_W +: DATA_W]),
      .i_acc_init  (w_acc_init),
      .i_acc_en    (w_acc_en),
      .i_x         (in_data),
      .i_idx       (r_idx),
      .i_capture   (w_last),
      .i_relu_en   (relu_en),
      .o_score_nxt (w_score_nxt[j]),
      .o_score     (class_out[j*DATA_W +: DATA_W])
    );
  end

  // Strict '>' keeps the lowest lane on ties.
  always_comb begin
    w_best_val = w_score_nxt[0];
    w_best_idx = '0;
    for (int j = 1; j < N_OUT; j++) begin
      if (w_score_nxt[j] > w_best_val) begin
        w_best_val = w_score_nxt[j];
        w_best_idx = CIW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_LOAD;
      r_wcnt         <= '0;
      r_idx          <= '0;
      r_in_ready     <= 1'b0;
      w_ready        <= 1'b1;
      out_valid      <= 1'b0;
      weights_loaded <= 1'b0;
      class_idx      <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_valid) begin
            if (r_wcnt == WCW'(N_IN)) begin
              r_wcnt         <= '0;
              r_idx          <= '0;
              r_state        <= ST_RUN;
              w_ready        <= 1'b0;
              r_in_ready     <= 1'b1;
              weights_loaded <= 1'b1;
            end else begin
              r_wcnt <= r_wcnt + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_reload_hit) begin
            r_state        <= ST_LOAD;
            r_wcnt         <= '0;
            w_ready        <= 1'b1;
            r_in_ready     <= 1'b0;
            weights_loaded <= 1'b0;
          end else if (w_acc_en) begin
            if (w_last) begin
              r_idx      <= '0;
              r_state    <= ST_OUT;
              r_in_ready <= 1'b0;
              out_valid  <= 1'b1;
              class_idx  <= w_best_idx;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            r_state    <= ST_RUN;
            r_in_ready <= 1'b1;
            out_valid  <= 1'b0;
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

endmodule
